// File: rtl/flex_down_counter.sv
// Loadable down-counter / interval timer with one-shot or periodic terminal-count behaviour.
// Periodic reload is present only when FLEX_DOWN_CNT_AUTO_RELOAD_EN is defined; otherwise one-shot only.
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    done,
  output logic                    expired
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    expired_q, expired_d;
  logic [NUM_CNT_BITS-1:0] reload_q;

`ifdef FLEX_DOWN_CNT_AUTO_RELOAD_EN
  logic [NUM_CNT_BITS-1:0] reload_d;
  logic                    periodic;

  assign periodic = auto_reload;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end

  always_comb begin
    reload_d = reload_q;
    if (clear) begin
      reload_d = '0;
    end else if (load) begin
      reload_d = load_val;
    end
  end
`else
  logic periodic;
  logic unused_cfg;

  // Without the reload register every terminal count is one-shot.
  assign reload_q   = '0;
  assign periodic   = 1'b0;
  assign unused_cfg = auto_reload ^ (|reload_q);
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
      state_d = (load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN && count_enable) begin
      // count_q is never 0 in RUN, so anything not above 1 is the terminal value.
      if (count_q > NUM_CNT_BITS'(1)) begin
        count_d = count_q - NUM_CNT_BITS'(1);
      end else begin
        expired_d = 1'b1;
        if (periodic) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign count_out = count_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign expired   = expired_q;

endmodule

// File: doc/flex_down_counter.md
# flex_down_counter

Parameterized loadable down-counter and interval timer, the count-down companion to the team's up-counting flex counter. A value loaded through `load`/`load_val` is decremented on each enabled cycle. Reaching terminal count raises a one-cycle `expired` pulse, and the block either stops (one-shot) or reloads (periodic). Used by the lab datapaths as the bit-period, timeout and wait-state timer.

## Interface
Parameters:
- NUM_CNT_BITS, 4, width of count, load value and reload register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear; highest priority after reset.
- load  input  1  synchronous load of `load_val`; starts a new run.
- load_val  input  NUM_CNT_BITS  start value and reload value, sampled when `load`=1.
- count_enable  input  1  decrement qualifier while running.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at terminal count.
- count_out  output  NUM_CNT_BITS  current count, registered.
- busy  output  1  registered; high in RUN.
- done  output  1  registered; high in DONE (one-shot finished).
- expired  output  1  registered one-cycle pulse on terminal count.

## Operation
- Internal state: FSM {IDLE, RUN, DONE}, `count_out`, reload register `reload_q` (NUM_CNT_BITS).
- Priority each edge: n_rst > clear > load > count_enable.
- clear (any state): count_out=0, reload_q=0, state=IDLE, expired=0.
- load (any state, clear=0): reload_q=load_val, count_out=load_val, expired=0.
  - load_val≠0: state=RUN. load_val=0: state=IDLE.
  - A load in RUN restarts the run with no pulse for the abandoned run.
- IDLE: hold. count_enable ignored.
- RUN, count_enable=0: hold everything.
- RUN, count_enable=1, count_out>1: count_out = count_out−1.
- RUN, count_enable=1, count_out==1 (terminal): expired=1 next cycle.
  - auto_reload=1: count_out=reload_q, stay RUN.
  - auto_reload=0: count_out=0, state=DONE.
- DONE: count_out holds 0 and done=1 until load or clear. count_enable ignored.
- Period in auto-reload mode is exactly reload_q enabled cycles. Arithmetic is unsigned. Because count_out is never 0 in RUN, decrement never wraps below 0.
- busy = (state==RUN); done = (state==DONE). Both are derived from the registered state, with no combinational path from inputs.

## Timing
- Reset values: count_out=0, reload_q=0, state=IDLE, busy=0, done=0, expired=0.
- Load latency 1: load sampled at edge k, so count_out=load_val and busy=1 after edge k.
- Decrement latency 1 per enabled cycle.
- expired is high for exactly the one cycle following the terminal edge, concurrent with the new count_out (reload value or 0). It is never high for 2 consecutive cycles unless reload_q=1 with continuous enable.
- Simultaneous events:
  - load at the terminal cycle: load wins, no expired pulse.
  - clear with load: clear wins.
  - auto_reload change mid-run affects only the next terminal event.
- n_rst assertion mid-run immediately forces all reset values, asynchronously, with no pulse.

## Configuration
- Macro `FLEX_DOWN_CNT_AUTO_RELOAD_EN`.
- Defined: behaviour as above. The reload register exists and `auto_reload` selects the mode.
- Undefined: the `auto_reload` port remains but is ignored, and the block is one-shot only. The reload register is not instantiated; reload_q reads as 0. Every terminal count goes to DONE with count_out=0.
- All other behaviour and timing are identical in both configurations.

## Test plan
- Reset: drive n_rst=0 mid-run with count_out=5 → all outputs 0 immediately; after release, state is IDLE and count_enable is ignored.
- One-shot (NUM_CNT_BITS=4, auto_reload=0): load 3, continuous enable → count_out 3,2,1,0; expired high only in the cycle count_out=0; done=1, busy=0; holds 0 under further enable.
- Auto-reload (macro defined): load 4, auto_reload=1, continuous enable → sequence 4,3,2,1,4,3,… with expired every 4th cycle, aligned to each return to 4. Macro undefined: same stimulus stops at 0 with done=1.
- Gated enable: load 2, toggle count_enable 1,0,0,1 → count_out 2,1,1,1,0 and expired is delayed accordingly. load_val=0 → stays IDLE, busy=0, no pulse.
- Collisions: load 9 on the terminal cycle of a run → count_out=9, expired stays 0. clear and load together → count_out=0, IDLE. load 15 (all ones) → counts down 15 cycles without wrap.
